// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter, WB stage over queued aux results
// Optional feature macro: WB_WAW_KILL_EN (WB writes invalidate older queued aux writes to the same register)
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_reg_write,
  input  logic [ADDR_W-1:0]        pipe_write_reg,
  input  logic [DATA_W-1:0]        pipe_write_data,
  input  logic                     aux_valid,
  output logic                     aux_ready,
  input  logic [ADDR_W-1:0]        aux_write_reg,
  input  logic [DATA_W-1:0]        aux_write_data,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_write_reg,
  output logic [DATA_W-1:0]        rf_write_data,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   aux_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  logic [ADDR_W-1:0] mem_reg_q  [DEPTH];
  logic [ADDR_W-1:0] mem_reg_d  [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              stall_q, stall_d;
`ifdef WB_WAW_KILL_EN
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              kill;
`endif

  logic empty;
  logic push;
  logic pop;
  logic head_valid;

  assign aux_count = count_q;
  assign stall_req = stall_q;

  // Handshake and port select; the WB path is purely combinational so it adds no latency
  always_comb begin
    empty         = (count_q == '0);
    aux_ready     = !rst && (count_q != FULL_CNT);
    push          = aux_valid && aux_ready;
    pop           = !rst && !pipe_reg_write && !empty;
`ifdef WB_WAW_KILL_EN
    head_valid    = valid_q[rd_ptr_q];
    kill          = pipe_reg_write && (pipe_write_reg != '0);
`else
    head_valid    = 1'b1;
`endif
    rf_write      = 1'b0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    if (pipe_reg_write) begin
      rf_write      = !rst && (pipe_write_reg != '0);
      rf_write_reg  = pipe_write_reg;
      rf_write_data = pipe_write_data;
    end else if (!empty) begin
      rf_write      = !rst && head_valid && (mem_reg_q[rd_ptr_q] != '0);
      rf_write_reg  = mem_reg_q[rd_ptr_q];
      rf_write_data = mem_data_q[rd_ptr_q];
    end
  end

  // FIFO, starvation counter and stall request next state
  always_comb begin
    mem_reg_d  = mem_reg_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    starve_d   = starve_q;
    stall_d    = stall_q;
`ifdef WB_WAW_KILL_EN
    valid_d    = valid_q;
    // The WB instruction is younger than anything queued, so matching entries are stale
    for (int i = 0; i < DEPTH; i++) begin
      if (kill && (mem_reg_q[i] == pipe_write_reg)) valid_d[i] = 1'b0;
    end
`endif
    if (push) begin
      mem_reg_d[wr_ptr_q]  = aux_write_reg;
      mem_data_d[wr_ptr_q] = aux_write_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
`ifdef WB_WAW_KILL_EN
      valid_d[wr_ptr_q]    = !(kill && (aux_write_reg == pipe_write_reg));
`endif
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (pop || empty) begin
      starve_d = '0;
    end else if (pipe_reg_write && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + STV_W'(1);
    end
    if (pop) begin
      stall_d = 1'b0;
    end else if (starve_d == STARVE_MAX) begin
      stall_d = 1'b1;
    end
  end

  // State registers; reset discards every queued entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg_q[i]  <= '0;
        mem_data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
`ifdef WB_WAW_KILL_EN
      valid_q  <= '0;
`endif
    end else begin
      mem_reg_q  <= mem_reg_d;
      mem_data_q <= mem_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
`ifdef WB_WAW_KILL_EN
      valid_q    <= valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_reg_write;
  logic [4:0]  pipe_write_reg;
  logic [31:0] pipe_write_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_write_reg;
  logic [31:0] aux_write_data;
  logic        rf_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        stall_req;
  logic [2:0]  aux_count;

  int total;
  int bad;

`ifdef WB_WAW_KILL_EN
  localparam bit KILL = 1'b1;
`else
  localparam bit KILL = 1'b0;
`endif

  logic [31:0] rf_model [32];

  wb_port_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .pipe_reg_write  (pipe_reg_write),
    .pipe_write_reg  (pipe_write_reg),
    .pipe_write_data (pipe_write_data),
    .aux_valid       (aux_valid),
    .aux_ready       (aux_ready),
    .aux_write_reg   (aux_write_reg),
    .aux_write_data  (aux_write_data),
    .rf_write        (rf_write),
    .rf_write_reg    (rf_write_reg),
    .rf_write_data   (rf_write_data),
    .stall_req       (stall_req),
    .aux_count       (aux_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fed by the arbitrated write port
  always @(posedge clk) begin
    if (!rst && rf_write) rf_model[rf_write_reg] <= rf_write_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_reg_write  = 1'b0;
    pipe_write_reg  = '0;
    pipe_write_data = '0;
    aux_valid       = 1'b0;
    aux_write_reg   = '0;
    aux_write_data  = '0;
  endtask

  task automatic test_reset();
    idle();
    aux_valid = 1'b1;
    rst = 1'b1;
    #2;
    total++; if (aux_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", aux_count); end
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
    total++; if (aux_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", aux_ready); end
    total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL reset_rf_write got=%b exp=0", rf_write); end
    tick();
    tick();
    idle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wb_path();
    pipe_reg_write = 1'b1; pipe_write_reg = 5'd5; pipe_write_data = 32'h11;
    #1;
    total++; if ({rf_write, rf_write_reg, rf_write_data} !== {1'b1, 5'd5, 32'h11}) begin
      bad++; $display("FAIL wb_path got=%b/%0d/%h exp=1/5/11", rf_write, rf_write_reg, rf_write_data); end
    total++; if (aux_ready !== 1'b1) begin bad++; $display("FAIL wb_ready got=%b exp=1", aux_ready); end
    total++; if (aux_count !== 3'd0) begin bad++; $display("FAIL wb_count got=%0d exp=0", aux_count); end
    tick();
    idle();
    tick();
    total++; if (rf_model[5] !== 32'h11) begin bad++; $display("FAIL wb_rf5 got=%h exp=11", rf_model[5]); end
  endtask

  task automatic test_aux_latency();
    aux_valid = 1'b1; aux_write_reg = 5'd7; aux_write_data = 32'hAA;
    #1;
    total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL aux_no_bypass got=%b exp=0", rf_write); end
    tick();
    idle();
    #1;
    total++; if (aux_count !== 3'd1) begin bad++; $display("FAIL aux_count1 got=%0d exp=1", aux_count); end
    total++; if ({rf_write, rf_write_reg, rf_write_data} !== {1'b1, 5'd7, 32'hAA}) begin
      bad++; $display("FAIL aux_drain got=%b/%0d/%h exp=1/7/aa", rf_write, rf_write_reg, rf_write_data); end
    tick();
    total++; if (aux_count !== 3'd0) begin bad++; $display("FAIL aux_count0 got=%0d exp=0", aux_count); end
    total++; if ({rf_write, rf_write_reg, rf_write_data} !== {1'b0, 5'd0, 32'h0}) begin
      bad++; $display("FAIL aux_idle got=%b/%0d/%h exp=0/0/0", rf_write, rf_write_reg, rf_write_data); end
  endtask

  task automatic test_starvation();
    pipe_reg_write = 1'b1; pipe_write_reg = 5'd3; pipe_write_data = 32'h33;
    for (int i = 0; i < 4; i++) begin
      aux_valid = 1'b1; aux_write_reg = 5'(10 + i); aux_write_data = 32'h100 + i;
      tick();
    end
    aux_valid = 1'b0;
    #1;
    // Starve counter is 3 here: edges after the first push each saw a blocked cycle
    total++; if (aux_count !== 3'd4) begin bad++; $display("FAIL starve_full_count got=%0d exp=4", aux_count); end
    total++; if (aux_ready !== 1'b0) begin bad++; $display("FAIL starve_full_ready got=%b exp=0", aux_ready); end
    total++; if ({rf_write, rf_write_reg} !== {1'b1, 5'd3}) begin
      bad++; $display("FAIL starve_wb_prio got=%b/%0d exp=1/3", rf_write, rf_write_reg); end
    for (int i = 0; i < 4; i++) begin
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL starve_early step=%0d got=%b exp=0", i, stall_req); end
      tick();
    end
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL starve_seven got=%b exp=0", stall_req); end
    tick();
    total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL starve_raise got=%b exp=1", stall_req); end
    tick();
    total++; if ({stall_req, rf_write, rf_write_reg} !== {1'b1, 1'b1, 5'd3}) begin
      bad++; $display("FAIL starve_hold got=%b/%b/%0d exp=1/1/3", stall_req, rf_write, rf_write_reg); end
    pipe_reg_write = 1'b0;
    #1;
    total++; if ({rf_write, rf_write_reg, rf_write_data} !== {1'b1, 5'd10, 32'h100}) begin
      bad++; $display("FAIL starve_pop_head got=%b/%0d/%h exp=1/10/100", rf_write, rf_write_reg, rf_write_data); end
    total++; if (aux_ready !== 1'b0) begin bad++; $display("FAIL starve_pop_ready got=%b exp=0", aux_ready); end
    tick();
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL starve_drop got=%b exp=0", stall_req); end
    total++; if (aux_count !== 3'd3) begin bad++; $display("FAIL starve_count3 got=%0d exp=3", aux_count); end
    for (int i = 1; i < 4; i++) begin
      total++; if ({rf_write, rf_write_reg, rf_write_data} !== {1'b1, 5'(10 + i), 32'h100 + i}) begin
        bad++; $display("FAIL starve_drain idx=%0d got=%b/%0d/%h", i, rf_write, rf_write_reg, rf_write_data); end
      tick();
    end
    total++; if (aux_count !== 3'd0) begin bad++; $display("FAIL starve_empty got=%0d exp=0", aux_count); end
    total++; if (rf_model[13] !== 32'h103) begin bad++; $display("FAIL starve_rf13 got=%h exp=103", rf_model[13]); end
  endtask

  task automatic test_reg_zero();
    pipe_reg_write = 1'b1; pipe_write_reg = 5'd0; pipe_write_data = 32'h55;
    #1;
    total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL r0_pipe got=%b exp=0", rf_write); end
    tick();
    idle();
    aux_valid = 1'b1; aux_write_reg = 5'd0; aux_write_data = 32'h77;
    tick();
    idle();
    #1;
    total++; if ({aux_count, rf_write} !== {3'd1, 1'b0}) begin
      bad++; $display("FAIL r0_aux got=%0d/%b exp=1/0", aux_count, rf_write); end
    tick();
    total++; if (aux_count !== 3'd0) begin bad++; $display("FAIL r0_pop got=%0d exp=0", aux_count); end
  endtask

  task automatic test_reset_mid_drain();
    pipe_reg_write = 1'b1; pipe_write_reg = 5'd2; pipe_write_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      aux_valid = 1'b1; aux_write_reg = 5'(21 + i); aux_write_data = 32'h200 + i;
      tick();
    end
    idle();
    #1;
    total++; if ({rf_write, rf_write_reg} !== {1'b1, 5'd21}) begin
      bad++; $display("FAIL mid_first got=%b/%0d exp=1/21", rf_write, rf_write_reg); end
    tick();
    rst = 1'b1;
    #1;
    total++; if ({aux_count, rf_write, stall_req, aux_ready} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL mid_reset got=%0d/%b/%b/%b exp=0/0/0/0", aux_count, rf_write, stall_req, aux_ready); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({rf_write, aux_count} !== {1'b0, 3'd0}) begin
        bad++; $display("FAIL mid_after step=%0d got=%b/%0d exp=0/0", i, rf_write, aux_count); end
      tick();
    end
    total++; if ({rf_model[22], rf_model[23]} !== 64'h0) begin
      bad++; $display("FAIL mid_discard got=%h/%h exp=0/0", rf_model[22], rf_model[23]); end
  endtask

  task automatic test_waw();
    pipe_reg_write = 1'b1; pipe_write_reg = 5'd4; pipe_write_data = 32'h4;
    aux_valid = 1'b1; aux_write_reg = 5'd9; aux_write_data = 32'h1;
    tick();
    aux_valid = 1'b0;
    pipe_write_reg = 5'd9; pipe_write_data = 32'h2;
    #1;
    total++; if ({rf_write, rf_write_reg, rf_write_data, aux_count} !== {1'b1, 5'd9, 32'h2, 3'd1}) begin
      bad++; $display("FAIL waw_wb got=%b/%0d/%h/%0d exp=1/9/2/1", rf_write, rf_write_reg, rf_write_data, aux_count); end
    tick();
    idle();
    #1;
    total++; if (rf_write !== !KILL) begin bad++; $display("FAIL waw_pop got=%b exp=%b", rf_write, !KILL); end
    tick();
    total++; if (rf_model[9] !== (KILL ? 32'h2 : 32'h1)) begin
      bad++; $display("FAIL waw_rf9 got=%h exp=%h", rf_model[9], KILL ? 32'h2 : 32'h1); end
    total++; if (aux_count !== 3'd0) begin bad++; $display("FAIL waw_count got=%0d exp=0", aux_count); end
    pipe_reg_write = 1'b1; pipe_write_reg = 5'd6; pipe_write_data = 32'h6;
    aux_valid = 1'b1; aux_write_reg = 5'd6; aux_write_data = 32'h60;
    tick();
    idle();
    #1;
    total++; if ({rf_write, aux_count} !== {!KILL, 3'd1}) begin
      bad++; $display("FAIL waw_same_cycle got=%b/%0d exp=%b/1", rf_write, aux_count, !KILL); end
    tick();
    total++; if (rf_model[6] !== (KILL ? 32'h6 : 32'h60)) begin
      bad++; $display("FAIL waw_rf6 got=%h exp=%h", rf_model[6], KILL ? 32'h6 : 32'h60); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    test_reset();
    test_wb_path();
    test_aux_latency();
    test_starvation();
    test_reg_zero();
    test_reset_mid_drain();
    test_waw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
